// File: rtl/dsi_pkt_protect.sv
// DSI transmit packet protection: byte-clock divider, header ECC and payload CRC.
// Everything runs on pclk; dsi_clk is a registered output only.
module dsi_pkt_protect #(
  parameter int unsigned DIV_HALF = 1,
  parameter logic [15:0] CRC_SEED = 16'hFFFF
) (
  input  logic        pclk,
  input  logic        dsi_rst,
  output logic        dsi_clk,
  input  logic        hdr_valid,
  input  logic [23:0] hdr_data,
  output logic [7:0]  ecc,
  output logic        ecc_done,
  input  logic        crc_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        crc_last,
  output logic [15:0] crc,
  output logic        crc_done
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned HDR_W  = 24;
  localparam int unsigned PAR_W  = 6;
  localparam int unsigned ECC_W  = 8;
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_HALF - 1);
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h8408;

  // ---------------------------------------------------------------------------
  // Clock divider: toggle dsi_clk every DIV_HALF pclk edges.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_cnt_nxt;
  logic             dsi_clk_nxt;

  always_comb begin
    div_cnt_nxt = div_cnt + CNT_W'(1);
    dsi_clk_nxt = dsi_clk;
    if (div_cnt == CNT_LAST) begin
      div_cnt_nxt = '0;
      dsi_clk_nxt = ~dsi_clk;
    end
  end

  always_ff @(posedge pclk or negedge dsi_rst) begin
    if (!dsi_rst) begin
      div_cnt <= '0;
      dsi_clk <= 1'b0;
    end else begin
      div_cnt <= div_cnt_nxt;
      dsi_clk <= dsi_clk_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Header ECC: 6-bit Hamming parity over DI + WC.
  // ---------------------------------------------------------------------------
  function automatic logic [PAR_W-1:0] hdr_parity(input logic [HDR_W-1:0] d);
    logic [PAR_W-1:0] p;
    p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^
           d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^
           d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^
           d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^
           d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^
           d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^
           d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

  logic [ECC_W-1:0] ecc_nxt;
  logic             ecc_done_nxt;

  always_comb begin
    ecc_nxt      = ecc;
    ecc_done_nxt = 1'b0;
    if (hdr_valid) begin
      ecc_nxt      = {2'b00, hdr_parity(hdr_data)};
      ecc_done_nxt = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge dsi_rst) begin
    if (!dsi_rst) begin
      ecc      <= '0;
      ecc_done <= 1'b0;
    end else begin
      ecc      <= ecc_nxt;
      ecc_done <= ecc_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload CRC: reflected x^16+x^12+x^5+1, one byte folded per cycle.
  // ---------------------------------------------------------------------------
  function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0] c,
                                                input logic [BYTE_W-1:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[CRC_W-1:1]} ^ (fb ? CRC_POLY : '0);
    end
    return r;
  endfunction

  logic [CRC_W-1:0] crc_acc;
  logic [CRC_W-1:0] crc_base;
  logic [CRC_W-1:0] crc_post;
  logic [CRC_W-1:0] crc_acc_nxt;
  logic [CRC_W-1:0] crc_nxt;
  logic             crc_done_nxt;

  // crc_start overrides the accumulator so a byte on the same cycle folds onto the seed.
  always_comb begin
    crc_base     = crc_start ? CRC_SEED : crc_acc;
    crc_post     = byte_valid ? crc_fold(crc_base, byte_data) : crc_base;
    crc_acc_nxt  = crc_post;
    crc_nxt      = crc;
    crc_done_nxt = 1'b0;
    if (crc_last) begin
      crc_acc_nxt  = CRC_SEED;
      crc_nxt      = crc_post;
      crc_done_nxt = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge dsi_rst) begin
    if (!dsi_rst) begin
      crc_acc  <= CRC_SEED;
      crc      <= '0;
      crc_done <= 1'b0;
    end else begin
      crc_acc  <= crc_acc_nxt;
      crc      <= crc_nxt;
      crc_done <= crc_done_nxt;
    end
  end

endmodule

// File: tb/tb_dsi_pkt_protect.sv
// Directed plus randomized bench for dsi_pkt_protect against a behavioural
// ECC/CRC reference; two instances cover DIV_HALF=3 and DIV_HALF=1.
module tb_dsi_pkt_protect;

  logic        pclk = 1'b0;
  logic        dsi_rst;
  logic        hdr_valid;
  logic [23:0] hdr_data;
  logic        crc_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        crc_last;

  logic        dsi_clk, dsi_clk1;
  logic [7:0]  ecc, ecc1;
  logic        ecc_done, ecc_done1;
  logic [15:0] crc, crc1;
  logic        crc_done, crc_done1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  exp_ecc = 8'h00;

  // Parity participation sets: bit i of mask p set when Di feeds Pp.
  logic [23:0] ecc_mask [6] = '{24'hF12CB7, 24'hF2555B, 24'h749A6D,
                                24'hB8E38E, 24'hDF03F0, 24'hEFFC00};
  logic [23:0] hv [3] = '{24'h000001, 24'h800000, 24'h000000};
  logic [7:0]  he [3] = '{8'h07, 8'h3B, 8'h00};

  always #5 pclk = ~pclk;

  dsi_pkt_protect #(.DIV_HALF(3), .CRC_SEED(16'hFFFF)) dut (
    .pclk(pclk), .dsi_rst(dsi_rst), .dsi_clk(dsi_clk),
    .hdr_valid(hdr_valid), .hdr_data(hdr_data), .ecc(ecc), .ecc_done(ecc_done),
    .crc_start(crc_start), .byte_valid(byte_valid), .byte_data(byte_data),
    .crc_last(crc_last), .crc(crc), .crc_done(crc_done)
  );

  dsi_pkt_protect #(.DIV_HALF(1), .CRC_SEED(16'hFFFF)) dut_d1 (
    .pclk(pclk), .dsi_rst(dsi_rst), .dsi_clk(dsi_clk1),
    .hdr_valid(hdr_valid), .hdr_data(hdr_data), .ecc(ecc1), .ecc_done(ecc_done1),
    .crc_start(crc_start), .byte_valid(byte_valid), .byte_data(byte_data),
    .crc_last(crc_last), .crc(crc1), .crc_done(crc_done1)
  );

  function automatic logic [7:0] ecc_ref(input logic [23:0] d);
    logic [7:0] r;
    r = 8'h00;
    for (int p = 0; p < 6; p++) r[p] = ^(d & ecc_mask[p]);
    return r;
  endfunction

  // Serial LSB-first division over the flattened payload bit stream.
  function automatic logic [15:0] crc_ref(input logic [7:0] q[$]);
    logic [15:0] r;
    logic        mix;
    r = 16'hFFFF;
    foreach (q[j]) begin
      for (int b = 0; b < 8; b++) begin
        mix = r[0] ^ q[j][b];
        r   = r >> 1;
        if (mix) r = r ^ 16'h8408;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic clear_crc_in();
    crc_start  = 1'b0;
    crc_last   = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic rnd_hdr();
    hdr_valid = 1'($urandom_range(0, 1));
    hdr_data  = 24'($urandom);
  endtask

  task automatic chk_hdr();
    if (hdr_valid) exp_ecc = ecc_ref(hdr_data);
    chk("ecc", 32'(ecc), 32'(exp_ecc));
    chk("ecc_done", 32'(ecc_done), 32'(hdr_valid));
    chk("ecc_d1", 32'(ecc1), 32'(exp_ecc));
  endtask

  // Streams "123456789"; gap_mask bit i inserts an idle cycle before byte i.
  task automatic send_string(input int gap_mask);
    for (int i = 0; i < 9; i++) begin
      if (gap_mask[i]) begin
        clear_crc_in();
        tick();
        chk("str_gap_done", 32'(crc_done), 0);
      end
      crc_start  = (i == 0);
      crc_last   = (i == 8);
      byte_valid = 1'b1;
      byte_data  = 8'(8'h31 + i);
      tick();
      chk("str_done", 32'(crc_done), 32'(i == 8));
    end
    clear_crc_in();
    chk("str_crc", 32'(crc), 32'h6F91);
    chk("str_crc_d1", 32'(crc1), 32'h6F91);
    tick();
    chk("str_done_clr", 32'(crc_done), 0);
    chk("str_crc_hold", 32'(crc), 32'h6F91);
  endtask

  initial begin
    logic [7:0] q[$];
    int w;
    int len;
    int junk;
    bit use_start;

    dsi_rst = 1'b0;
    hdr_valid = 1'b0;
    hdr_data = '0;
    clear_crc_in();
    tick();
    tick();
    chk("rst_dsi_clk", 32'(dsi_clk), 0);
    chk("rst_dsi_clk_d1", 32'(dsi_clk1), 0);
    chk("rst_ecc", 32'(ecc), 0);
    chk("rst_ecc_done", 32'(ecc_done), 0);
    chk("rst_crc", 32'(crc), 0);
    chk("rst_crc_done", 32'(crc_done), 0);

    // Divider: k edges after release -> dsi_clk = (k / DIV_HALF) % 2.
    dsi_rst = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("div3", 32'(dsi_clk), 32'((k / 3) % 2));
      chk("div1", 32'(dsi_clk1), 32'(k % 2));
    end

    w = 0;
    while (dsi_clk !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    chk("div3_high_seen", 32'(dsi_clk), 1);
    dsi_rst = 1'b0;
    #1;
    chk("rst_async_dsi_clk", 32'(dsi_clk), 0);
    chk("rst_async_dsi_clk_d1", 32'(dsi_clk1), 0);
    tick();
    dsi_rst = 1'b1;
    exp_ecc = 8'h00;

    // ECC singles with hold cycles.
    for (int i = 0; i < 3; i++) begin
      hdr_valid = 1'b1;
      hdr_data  = hv[i];
      tick();
      chk("ecc_single", 32'(ecc), 32'(he[i]));
      chk("ecc_single_done", 32'(ecc_done), 1);
      hdr_valid = 1'b0;
      hdr_data  = 24'($urandom);
      tick();
      chk("ecc_hold", 32'(ecc), 32'(he[i]));
      chk("ecc_hold_done", 32'(ecc_done), 0);
    end

    // ECC back-to-back.
    for (int i = 0; i < 3; i++) begin
      hdr_valid = 1'b1;
      hdr_data  = hv[i];
      tick();
      chk("ecc_b2b", 32'(ecc), 32'(he[i]));
      chk("ecc_b2b_done", 32'(ecc_done), 1);
    end
    hdr_valid = 1'b0;
    tick();
    chk("ecc_b2b_end", 32'(ecc_done), 0);
    exp_ecc = 8'h00;

    // CRC check string, then with gaps, then empty payload.
    send_string(0);
    send_string(32'h0124);
    crc_start = 1'b1;
    crc_last  = 1'b1;
    tick();
    chk("empty_crc", 32'(crc), 32'hFFFF);
    chk("empty_done", 32'(crc_done), 1);
    clear_crc_in();
    tick();
    chk("empty_done_clr", 32'(crc_done), 0);

    // Reset in the middle of a payload.
    for (int i = 0; i < 4; i++) begin
      crc_start  = (i == 0);
      byte_valid = 1'b1;
      byte_data  = 8'(8'h31 + i);
      hdr_valid  = (i == 3);
      hdr_data   = 24'h800000;
      tick();
      chk("partial_done", 32'(crc_done), 0);
    end
    clear_crc_in();
    hdr_valid = 1'b0;
    chk("pre_rst_ecc", 32'(ecc), 32'h3B);
    dsi_rst = 1'b0;
    #1;
    chk("midpay_rst_crc", 32'(crc), 0);
    chk("midpay_rst_done", 32'(crc_done), 0);
    chk("midpay_rst_ecc", 32'(ecc), 0);
    tick();
    dsi_rst = 1'b1;
    tick();
    chk("post_rst_done", 32'(crc_done), 0);
    exp_ecc = 8'h00;
    send_string(0);

    // Randomized payloads with concurrent header traffic.
    for (int p = 0; p < 30; p++) begin
      q.delete();
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      use_start = ($urandom_range(0, 3) != 0);
      junk = 0;
      if (use_start) junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        crc_start  = 1'b0;
        crc_last   = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'($urandom);
        rnd_hdr();
        tick();
        chk_hdr();
        chk("rnd_junk_done", 32'(crc_done), 0);
      end
      if (len == 0) begin
        crc_start  = use_start;
        crc_last   = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        rnd_hdr();
        tick();
        chk_hdr();
        chk("rnd_empty_done", 32'(crc_done), 1);
        chk("rnd_empty_crc", 32'(crc), 32'(crc_ref(q)));
      end else begin
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            clear_crc_in();
            rnd_hdr();
            tick();
            chk_hdr();
            chk("rnd_gap_done", 32'(crc_done), 0);
          end
          crc_start  = (i == 0) && use_start;
          crc_last   = (i == len - 1);
          byte_valid = 1'b1;
          byte_data  = q[i];
          rnd_hdr();
          tick();
          chk_hdr();
          chk("rnd_done", 32'(crc_done), 32'(i == len - 1));
        end
        chk("rnd_crc", 32'(crc), 32'(crc_ref(q)));
      end
      clear_crc_in();
    end

    hdr_valid = 1'b0;
    tick();
    chk("final_done", 32'(crc_done), 0);
    chk("final_ecc_done", 32'(ecc_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
